key_expand_engine: RTL
======================

// Module: key_expand_engine
// PURPOSE
//  Sequential AES key-schedule engine; successor to the combinational RotWord/SubWord helpers.
//  Loads a cipher key and streams the expanded schedule w[0..4*(NK+7)-1], one 32-bit word per
//  accepted transfer, over a valid/ready port. Sits between the key register and round-key storage.
//  Supports AES-128/192/256 through NK; RotWord, SubWord (forward S-box) and Rcon are internal.
// PARAMETERS
//  NK     4   key length in 32-bit words; legal values 4, 6, 8 (others: $error at elaboration)
//  NW     4*(NK+7)   total schedule words (44/52/60); derived localparam, not overridable
// PORTS
//  clk      in   1    clock, rising edge
//  rst_n    in   1    asynchronous active-low reset
//  start    in   1    1-cycle request; sampled only in IDLE
//  key_in   in   256  cipher key, MSB-aligned: key_in[255 -: NK*32] used, rest ignored
//  w_valid  out  1    w_out/w_idx hold a schedule word
//  w_ready  in   1    sink accepts; transfer = w_valid & w_ready
//  w_out    out  32   schedule word w[w_idx], byte 0 in [31:24]
//  w_idx    out  6    index of w_out, 0..NW-1
//  busy     out  1    high from accepted start until the last transfer
//  done     out  1    1-cycle pulse the cycle after the last transfer
// BEHAVIOUR
//  Reset: state=IDLE; w_valid=0, w_out=0, w_idx=0, busy=0, done=0, window and rcon cleared.
//  Reset mid-operation aborts immediately; no partial words are emitted after release.
//  States: IDLE -> LOAD (start) ; LOAD -> EXPAND (after w[NK-1] transferred) ;
//    EXPAND -> DONE (after w[NW-1] transferred) ; DONE -> IDLE (1 cycle, done=1).
//  Start: in IDLE, start=1 latches key_in into an NK-word window, rcon=8'h01, busy=1; w_valid
//    rises next cycle with w[0]. start while busy or in DONE is ignored.
//  LOAD: emits key words w[0..NK-1] unchanged (w[0] = key_in[255:224]).
//  EXPAND, i = w_idx >= NK: t = window[NK-1] (= w[i-1]);
//    i%NK==0        : t = SubWord(RotWord(t)) ^ {rcon,24'h0}; then rcon = xtime(rcon)
//    NK==8 & i%NK==4: t = SubWord(t)
//    w[i] = window[0] (= w[i-NK]) ^ t; window shifts by one word on each transfer.
//  RotWord: {b1,b2,b3,b0}; rcon sequence 01,02,04,08,10,20,40,80,1B,36 (xtime reduces by 8'h1B).
//  i%NK tracked by a modulo-NK counter, no divider.
//  Throughput: one word per cycle when w_ready held high; first word 1 cycle after start.
//  Backpressure: while w_valid & !w_ready, w_out and w_idx stable, no state advances.
//  Next word is computed combinationally from the window and registered on the transfer edge.
//  w_valid drops the cycle after w[NW-1] transfers; busy falls with it; done pulses that cycle.
//  No counter wrap: w_idx never exceeds NW-1; rcon never advances past index NW/NK.
// CONFIGURATION
//  KEYEXP_SBOX_PIPE_EN defined: SubWord output registered; any word requiring SubWord takes 2
//    cycles (w_valid low for 1 bubble cycle before it); other words unaffected. Max rate NW+bubbles.
//  Undefined: S-box combinational in the same cycle; sustained 1 word/cycle, NW cycles total.
//  Schedule contents are identical either way; only w_valid timing differs.
// TESTING
//  1 NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, w_ready=1 -> w[4]=a0fafe17, w[43]=b6630ca6,
//    44 transfers in 44 cycles (macro off), done pulses once, busy low after.
//  2 NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> w[6]=fe0c91f7,
//    w[51]=01002202, 52 transfers.
//  3 NK=8, key 603deb10...0914dff4 (FIPS-197 A.3) -> w[8]=9ba35411, w[12]=a8b09c1a (SubWord-only
//    step), w[59]=706c631e, 60 transfers.
//  4 NK=4, random w_ready (50%) -> sequence identical to test 1; w_out/w_idx stable on stalled cycles.
//  5 start pulsed at w_idx=10 -> ignored, sequence unchanged; rst_n low at w_idx=20 -> all outputs
//    0 asynchronously; new start after release yields w[0] of the new key.
//  6 KEYEXP_SBOX_PIPE_EN, NK=4, w_ready=1 -> same words as test 1; exactly 10 bubble cycles
//    (w_valid low before w[4],w[8],...,w[40]); 54 cycles total.

Source files
------------

// File: rtl/key_expand_engine.sv
// key_expand_engine: sequential AES key schedule for AES-128/192/256 (NK = 4/6/8).
// Loads a cipher key and streams w[0..NW-1], one 32-bit word per transfer.
// Build option: KEYEXP_SBOX_PIPE_EN registers the SubWord result, which inserts
// one bubble cycle before every word that needs the S-box.
//
// Handshake (w_valid/w_ready): a word transfers on a rising clock edge where
// both are high. While w_valid is high and w_ready is low, w_out and w_idx
// are held and no state advances. w_valid only drops after a transfer.
module key_expand_engine #(
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key_in,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   w_idx,
  output logic         busy,
  output logic         done,
  output logic [1:0]   dbg_state
);

  localparam int         NW        = 4 * (NK + 7);
  localparam logic [5:0] LAST_IDX  = 6'(NW - 1);
  localparam logic [5:0] LOAD_LAST = 6'(NK - 1);
  localparam logic [2:0] MOD_LAST  = 3'(NK - 1);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_nk_check
    $error("key_expand_engine: NK must be 4, 6 or 8");
  end

  // Forward AES S-box, entry b at bits [2047-8*b -: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] win_q [NK];   // last NK schedule words, win_q[NK-1] newest
  logic [31:0] out_q;
  logic [5:0]  idx_q;
  logic [2:0]  mod_q;        // (w_idx + 1) % NK: position of the next word
  logic [7:0]  rcon_q;
  logic        valid_q;

  logic        xfer, active, in_load, last, need_rot, need_sub;
  logic        adv_load, adv_exp;
  logic [31:0] t_raw, sub_in, sub_comb, sub_val, t_fin, nxt_word, load_word;
  logic [2:0]  mod_nxt;
  logic [7:0]  rcon_nxt;
  logic        unused_key;

  assign unused_key = ^key_in;

`ifdef KEYEXP_SBOX_PIPE_EN
  logic [31:0] sub_q;
  logic        pend_q;     // SubWord captured, next word lands next cycle
  logic        go_pend;
`endif

  assign xfer     = valid_q & w_ready;
  assign active   = (state_q == S_LOAD) || (state_q == S_EXPAND);
  assign in_load  = idx_q < LOAD_LAST;
  assign last     = idx_q == LAST_IDX;
  assign need_rot = mod_q == 3'd0;
  assign need_sub = need_rot || ((NK == 8) && (mod_q == 3'd4));
  assign t_raw    = win_q[NK-1];
  assign sub_in   = need_rot ? {t_raw[23:0], t_raw[31:24]} : t_raw;
  assign sub_comb = sub_word(sub_in);
`ifdef KEYEXP_SBOX_PIPE_EN
  assign sub_val  = sub_q;
`else
  assign sub_val  = sub_comb;
`endif
  assign t_fin    = need_sub ? (sub_val ^ (need_rot ? {rcon_q, 24'h0} : 32'h0)) : t_raw;
  assign nxt_word = win_q[0] ^ t_fin;
  assign mod_nxt  = (mod_q == MOD_LAST) ? 3'd0 : mod_q + 3'd1;
  assign rcon_nxt = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  // Key word selected for the next LOAD transfer (mod_q equals its index there).
  always_comb begin
    load_word = '0;
    for (int k = 0; k < NK; k++) begin
      if (mod_q == 3'(k)) load_word = win_q[k];
    end
  end

  assign adv_load = active & xfer & in_load;
`ifdef KEYEXP_SBOX_PIPE_EN
  assign go_pend  = active & xfer & !in_load & !last & need_sub;
  assign adv_exp  = active & (pend_q | (xfer & !in_load & !last & !need_sub));
`else
  assign adv_exp  = active & xfer & !in_load & !last;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD;
      S_LOAD:   if (xfer && idx_q == LOAD_LAST) state_d = S_EXPAND;
      S_EXPAND: if (xfer && last) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: key load, word stepping, window shift and rcon update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NK; k++) win_q[k] <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      mod_q   <= '0;
      rcon_q  <= '0;
      valid_q <= 1'b0;
`ifdef KEYEXP_SBOX_PIPE_EN
      sub_q   <= '0;
      pend_q  <= 1'b0;
`endif
    end else begin
      if (state_q == S_IDLE && start) begin
        for (int k = 0; k < NK; k++) win_q[k] <= key_in[255 - 32 * k -: 32];
        out_q   <= key_in[255 -: 32];
        idx_q   <= '0;
        mod_q   <= 3'd1;
        rcon_q  <= 8'h01;
        valid_q <= 1'b1;
      end
      if (adv_load) begin
        out_q <= load_word;
        idx_q <= idx_q + 6'd1;
        mod_q <= mod_nxt;
      end
      if (adv_exp) begin
        out_q   <= nxt_word;
        idx_q   <= idx_q + 6'd1;
        mod_q   <= mod_nxt;
        valid_q <= 1'b1;
        if (need_rot) rcon_q <= rcon_nxt;
        for (int k = 0; k < NK - 1; k++) win_q[k] <= win_q[k+1];
        win_q[NK-1] <= nxt_word;
      end
`ifdef KEYEXP_SBOX_PIPE_EN
      if (go_pend) begin
        sub_q   <= sub_comb;
        pend_q  <= 1'b1;
        valid_q <= 1'b0;
      end
      if (adv_exp) pend_q <= 1'b0;
`endif
      if (active && xfer && last) valid_q <= 1'b0;
    end
  end

  assign w_valid   = valid_q;
  assign w_out     = out_q;
  assign w_idx     = idx_q;
  assign busy      = active;
  assign done      = state_q == S_DONE;
  assign dbg_state = state_q;

endmodule
